// File: rtl/types.sv
`default_nettype none
// ============================================================================
//  Module      : types (package)
//  Description : Shared widths, records and constants for the mina2000 core
//                pipeline stages and the data bus.
//  Revision    : 1.0  initial release
// ============================================================================
package types;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;
  typedef logic [4:0]  reg_addr_t;

  // Memory operation carried in the EX/MEM record; 2'b11 is illegal and
  // behaves exactly like NONE.
  typedef logic [1:0] mem_op_t;
  localparam mem_op_t MEM_OP_NONE    = 2'b00;
  localparam mem_op_t MEM_OP_LOAD    = 2'b01;
  localparam mem_op_t MEM_OP_STORE   = 2'b10;
  localparam mem_op_t MEM_OP_ILLEGAL = 2'b11;

  localparam wrstb_t WRSTB_WORD = 4'b1111;
  localparam wrstb_t WRSTB_NONE = 4'b0000;

  typedef struct packed {
    reg_addr_t rd_addr;
    u32_t      rd_data;
    mem_op_t   mem_op;
    u32_t      mem_data;
  } mem_params_t;

  typedef struct packed {
    reg_addr_t rd_addr;
    u32_t      rd_data;
  } wb_params_t;

  typedef enum logic [0:0] {MEM_ST_IDLE, MEM_ST_BUS} mem_state_e;

  typedef struct packed {
    logic   req;
    logic   we;
    u32_t   addr;
    u32_t   wdata;
    wrstb_t wrstb;
  } dbus_req_t;

  // True for operations that need a data-bus transaction.
  function automatic logic is_bus_op(mem_op_t op);
    return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline MEM stage. Passes non-memory instructions straight
//                to writeback, runs one data-bus transaction per load/store
//                while stalling upstream, and registers the WB record.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage
  import types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  mem_params_t in_params,
  output logic        stall,
  output logic        out_valid,
  output wb_params_t  out_params,
  output logic        dbus_req,
  output logic        dbus_we,
  output u32_t        dbus_addr,
  output u32_t        dbus_wdata,
  output wrstb_t      dbus_wrstb,
  input  logic        dbus_ack,
  input  u32_t        dbus_rdata
);

  mem_state_e state_q, state_d;
  dbus_req_t  dbus_q, dbus_d;
  reg_addr_t  rd_addr_q, rd_addr_d;
  logic       out_valid_q, out_valid_d;
  wb_params_t out_params_q, out_params_d;

  // State, bus and writeback registers; reset also abandons any open request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= MEM_ST_IDLE;
      dbus_q       <= '0;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_params_q <= '0;
    end else begin
      state_q      <= state_d;
      dbus_q       <= dbus_d;
      rd_addr_q    <= rd_addr_d;
      out_valid_q  <= out_valid_d;
      out_params_q <= out_params_d;
    end
  end

  // Next-state, bus launch/retire and the combinational upstream stall.
  always_comb begin
    state_d      = state_q;
    dbus_d       = dbus_q;
    rd_addr_d    = rd_addr_q;
    out_valid_d  = 1'b0;
    out_params_d = out_params_q;
    stall        = 1'b0;

    case (state_q)
      MEM_ST_IDLE: begin
        if (in_valid) begin
          if (is_bus_op(in_params.mem_op)) begin
            // Hold upstream while the request is launched; the bus fields
            // then stay frozen in dbus_q until the responder acks.
            stall        = 1'b1;
            state_d      = MEM_ST_BUS;
            rd_addr_d    = in_params.rd_addr;
            dbus_d.req   = 1'b1;
            dbus_d.we    = (in_params.mem_op == MEM_OP_STORE);
            dbus_d.addr  = {in_params.rd_data[31:2], 2'b00};
            dbus_d.wdata = in_params.mem_data;
            dbus_d.wrstb = (in_params.mem_op == MEM_OP_STORE) ? WRSTB_WORD : WRSTB_NONE;
          end else begin
            out_valid_d  = 1'b1;
            out_params_d = '{rd_addr: in_params.rd_addr, rd_data: in_params.rd_data};
          end
        end
      end

      MEM_ST_BUS: begin
        if (dbus_ack) begin
          // Release upstream in the ack cycle so it advances at this edge.
          state_d     = MEM_ST_IDLE;
          dbus_d.req  = 1'b0;
          out_valid_d = 1'b1;
          if (dbus_q.we) begin
            out_params_d = '0;  // store retires as a harmless write to r0
          end else begin
            out_params_d = '{rd_addr: rd_addr_q, rd_data: dbus_rdata};
          end
        end else begin
          stall = 1'b1;
        end
      end
    endcase
  end

  assign out_valid  = out_valid_q;
  assign out_params = out_params_q;
  assign dbus_req   = dbus_q.req;
  assign dbus_we    = dbus_q.we;
  assign dbus_addr  = dbus_q.addr;
  assign dbus_wdata = dbus_q.wdata;
  assign dbus_wrstb = dbus_q.wrstb;

endmodule
`default_nettype wire
